// File: rtl/regfile_gen.sv
// DATA_W x 2^ADDR_W register file: byte-enabled write/read ports, hardwired-zero entry 0,
// sequential clear engine and pending-write scoreboard. Optional same-cycle forwarding: RF_BYPASS_EN.
module regfile_gen #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr_req,
    output logic                   busy,
    input  logic [DATA_W/8-1:0]    wen,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    ren1,
    input  logic [ADDR_W-1:0]      raddr1,
    output logic [DATA_W-1:0]      rdata1,
    input  logic [DATA_W/8-1:0]    ren2,
    input  logic [ADDR_W-1:0]      raddr2,
    output logic [DATA_W-1:0]      rdata2,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic                   pend1,
    output logic                   pend2,
    input  logic [ADDR_W-1:0]      test_addr,
    output logic [DATA_W-1:0]      test_data
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic [DEPTH-1:0]   r_pend;
    logic [DATA_W-1:0]  r_rf [DEPTH];

    logic               w_idle;
    logic               w_wr_any;
    logic [DATA_W-1:0]  w_rd1;
    logic [DATA_W-1:0]  w_rd2;
    logic [DATA_W-1:0]  w_tst;

    assign w_idle   = (r_state == IDLE);
    assign w_wr_any = w_idle && (wen != '0) && (waddr != '0);

    // Clear engine: walks every entry once, then hands over to normal operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Scoreboard: issue sets after the write-back clear, so a newer producer wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= '0;
        end else if (w_idle) begin
            if (clr_req) begin
                r_pend <= '0;
            end else begin
                for (int a = 1; a < int'(DEPTH); a++) begin
                    if ((wen != '0) && (waddr == ADDR_W'(a))) begin
                        r_pend[a] <= 1'b0;
                    end
                    if (iss_valid && (iss_addr == ADDR_W'(a))) begin
                        r_pend[a] <= 1'b1;
                    end
                end
                r_pend[0] <= 1'b0;
            end
        end
    end

    // Array storage is not reset; the clear engine defines its contents.
    always_ff @(posedge clk) begin
        if (!w_idle) begin
            r_rf[r_cnt] <= '0;
        end else if (w_wr_any) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wen[i]) begin
                    r_rf[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        w_tst = '0;
        if (w_idle) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (ren1[i] && (raddr1 != '0)) begin
                    w_rd1[8*i +: 8] = r_rf[raddr1][8*i +: 8];
`ifdef RF_BYPASS_EN
                    if ((raddr1 == waddr) && wen[i]) begin
                        w_rd1[8*i +: 8] = wdata[8*i +: 8];
                    end
`endif
                end
                if (ren2[i] && (raddr2 != '0)) begin
                    w_rd2[8*i +: 8] = r_rf[raddr2][8*i +: 8];
`ifdef RF_BYPASS_EN
                    if ((raddr2 == waddr) && wen[i]) begin
                        w_rd2[8*i +: 8] = wdata[8*i +: 8];
                    end
`endif
                end
            end
            if (test_addr != '0) begin
                w_tst = r_rf[test_addr];
            end
        end
    end

    assign busy      = !w_idle;
    assign rdata1    = w_rd1;
    assign rdata2    = w_rd2;
    assign test_data = w_tst;
    assign pend1     = w_idle && r_pend[raddr1];
    assign pend2     = w_idle && r_pend[raddr2];

endmodule

// File: tb/tb_regfile_gen.sv
// Directed self-checking bench for regfile_gen at DATA_W=32, ADDR_W=5.
module tb_regfile_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clr_req;
    logic        busy;
    logic [3:0]  wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  ren1, ren2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        pend1, pend2;
    logic [4:0]  test_addr;
    logic [31:0] test_data;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    regfile_gen #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .resetn(resetn), .clr_req(clr_req), .busy(busy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1),
        .ren2(ren2), .raddr2(raddr2), .rdata2(rdata2),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .pend1(pend1), .pend2(pend2),
        .test_addr(test_addr), .test_data(test_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; clr_req = 1'b0; wen = '0; waddr = '0; wdata = '0;
        ren1 = '0; ren2 = '0; raddr1 = '0; raddr2 = '0;
        iss_valid = 1'b0; iss_addr = '0; test_addr = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_pend1", 32'(pend1), 32'd0);
        chk("rst_pend2", 32'(pend2), 32'd0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_test_data", test_data, 32'h0);

        // Initial clear after reset release
        resetn = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            n++;
            if (!busy) break;
        end
        chk("reset_clear_cycles", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) begin
            test_addr = 5'(a);
            #1;
            chk("cleared_test_data", test_data, 32'h0);
        end

        // Byte-enabled write and read
        waddr = 5'd3; wdata = 32'hDEADBEEF; wen = 4'b0101;
        step();
        wen = '0; raddr1 = 5'd3; ren1 = 4'hF; test_addr = 5'd3;
        #1;
        chk("byte_wr_full_rd", rdata1, 32'h00AD00EF);
        chk("byte_wr_test_data", test_data, 32'h00AD00EF);
        ren1 = 4'b0011;
        #1;
        chk("byte_rd_mask", rdata1, 32'h000000EF);

        // Entry 0 is hardwired to zero
        waddr = 5'd0; wdata = 32'hFFFFFFFF; wen = 4'hF;
        step();
        wen = '0; raddr1 = '0; raddr2 = '0; ren1 = 4'hF; ren2 = 4'hF; test_addr = '0;
        #1;
        chk("zero_rdata1", rdata1, 32'h0);
        chk("zero_rdata2", rdata2, 32'h0);
        chk("zero_test_data", test_data, 32'h0);

        // Same-cycle write/read on port 2
        raddr2 = 5'd7; ren2 = 4'hF; waddr = 5'd7; wdata = 32'h12345678; wen = 4'hF;
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle", rdata2, 32'h12345678);
`else
        chk("bypass_same_cycle", rdata2, 32'h0);
`endif
        step();
        wen = '0;
        #1;
        chk("write_next_cycle", rdata2, 32'h12345678);

        // Scoreboard
        iss_valid = 1'b1; iss_addr = 5'd9; raddr1 = 5'd9;
        #1;
        chk("pend_before_edge", 32'(pend1), 32'd0);
        step();
        iss_valid = 1'b0;
        #1;
        chk("pend_set", 32'(pend1), 32'd1);
        waddr = 5'd9; wdata = 32'h0000_1111; wen = 4'hF; iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        wen = '0; iss_valid = 1'b0;
        #1;
        chk("pend_set_wins", 32'(pend1), 32'd1);
        waddr = 5'd9; wen = 4'h1;
        step();
        wen = '0;
        #1;
        chk("pend_cleared", 32'(pend1), 32'd0);
        iss_valid = 1'b1; iss_addr = 5'd0;
        step();
        iss_valid = 1'b0; raddr2 = 5'd0;
        #1;
        chk("pend_addr0", 32'(pend2), 32'd0);

        // Clear on request
        waddr = 5'd5; wdata = 32'hA5A5A5A5; wen = 4'hF; iss_valid = 1'b1; iss_addr = 5'd5;
        step();
        wen = '0; iss_valid = 1'b0; raddr1 = 5'd5; ren1 = 4'hF; test_addr = 5'd5;
        #1;
        chk("pre_clr_rdata1", rdata1, 32'hA5A5A5A5);
        chk("pre_clr_pend1", 32'(pend1), 32'd1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        #1;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_pend1", 32'(pend1), 32'd0);
        chk("clr_rdata1_busy", rdata1, 32'h0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            n++;
            if (n == 10) clr_req = 1'b1;
            if (n == 11) clr_req = 1'b0;
            if (!busy) break;
        end
        clr_req = 1'b0;
        chk("clr_cycles", 32'(n), 32'd32);
        #1;
        chk("post_clr_rdata1", rdata1, 32'h0);
        chk("post_clr_test_data", test_data, 32'h0);
        chk("post_clr_pend1", 32'(pend1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
